// File: rtl/det_stream_engine_if.sv
// det_stream_engine_if: control, ROM and result signals of the determinant
// stream engine. The engine connects through the master modport; the
// environment (ROM, sequencer, result consumer) uses the slave modport.
interface det_stream_engine_if #(
  parameter int DW = 4,
  parameter int AW = 4
);
  logic            start;
  logic [AW-1:0]   base_addr;
  logic [AW:0]     run_len;
  logic            hold;
  logic [AW-1:0]   rom_addr;
  logic [4*DW-1:0] rom_data;
  logic [2*DW:0]   det_out;
  logic            det_valid;
  logic            busy;
  logic            done;

  modport master (
    input  start, base_addr, run_len, hold, rom_data,
    output rom_addr, det_out, det_valid, busy, done
  );

  modport slave (
    output start, base_addr, run_len, hold, rom_data,
    input  rom_addr, det_out, det_valid, busy, done
  );
endinterface

// File: rtl/det_stream_engine.sv
// det_stream_engine: streams run_len packed words from an asynchronous ROM,
// starting at base_addr, and computes det = a*d - b*c for each word through
// a three-stage pipeline (operand latch, products, subtract).
// Optional build macro: DET_ACC_EN adds acc_out, a running sum of every
// result of the current run, cleared when a start is accepted.
module det_stream_engine #(
  parameter int DW          = 4,
  parameter int AW          = 4,
  parameter int SIGNED_MODE = 0
) (
  input  logic clk,
  input  logic reset,
  det_stream_engine_if.master bus
`ifdef DET_ACC_EN
  ,
  output logic [2*DW+AW:0] acc_out
`endif
);

  // Sign-extension enable: operands and products extend with their MSB
  // only in signed mode, otherwise with zeros.
  localparam logic          SX      = (SIGNED_MODE != 0);
  localparam logic [AW-1:0] PC_ONE  = 1;
  localparam logic [AW:0]   REM_ONE = 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t          state_reg, state_next;
  logic [AW-1:0]   pc_reg, pc_next;
  logic [AW:0]     rem_reg, rem_next;
  logic            issue;
  logic            accept;

  logic [4*DW-1:0] op_reg;
  logic [2*DW-1:0] op_x [4];
  logic            s1_valid_reg, s2_valid_reg, s3_valid_reg;
  logic [2*DW-1:0] ad_reg, bc_reg, ad_next, bc_next;
  logic [2*DW:0]   det_reg, det_next;

  // Sequencer: start acceptance, word issue, drain and done; hold freezes it.
  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    rem_next   = rem_reg;
    issue      = 1'b0;
    accept     = 1'b0;
    if (!bus.hold) begin
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            accept   = 1'b1;
            rem_next = bus.run_len;
            if (bus.run_len == '0) begin
              state_next = DONE;
            end else begin
              pc_next    = bus.base_addr;
              state_next = RUN;
            end
          end
        end
        RUN: begin
          issue    = 1'b1;
          pc_next  = pc_reg + PC_ONE;
          rem_next = rem_reg - REM_ONE;
          if (rem_reg == REM_ONE) state_next = DRAIN;
        end
        DRAIN: begin
          // S3 empties on the next edge once S1 and S2 are empty, so DONE
          // lines up with the cycle after the last result.
          if (!s1_valid_reg && !s2_valid_reg) state_next = DONE;
        end
        DONE: state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Sequencer state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      pc_reg    <= '0;
      rem_reg   <= '0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      rem_reg   <= rem_next;
    end
  end

  // Operand unpack: field 0=a, 1=c, 2=d, 3=b, each widened for the multiply.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_operand
      assign op_x[gi] = {{DW{SX & op_reg[gi*DW+DW-1]}}, op_reg[gi*DW +: DW]};
    end
  endgenerate

  // Widened operands make the 2*DW-bit product exact in both modes.
  assign ad_next  = op_x[0] * op_x[2];
  assign bc_next  = op_x[3] * op_x[1];
  assign det_next = {SX & ad_reg[2*DW-1], ad_reg} - {SX & bc_reg[2*DW-1], bc_reg};

  // Pipeline stages with valid bits; results hold between valid cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_reg <= 1'b0;
      s2_valid_reg <= 1'b0;
      s3_valid_reg <= 1'b0;
      op_reg       <= '0;
      ad_reg       <= '0;
      bc_reg       <= '0;
      det_reg      <= '0;
    end else if (!bus.hold) begin
      s1_valid_reg <= issue;
      s2_valid_reg <= s1_valid_reg;
      s3_valid_reg <= s2_valid_reg;
      if (issue) op_reg <= bus.rom_data;
      if (s1_valid_reg) begin
        ad_reg <= ad_next;
        bc_reg <= bc_next;
      end
      if (s2_valid_reg) det_reg <= det_next;
    end
  end

`ifdef DET_ACC_EN
  logic [2*DW+AW:0] acc_reg;

  // Run accumulator: cleared on accepted start, sums each emitted result.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_reg <= '0;
    end else if (!bus.hold) begin
      if (accept) acc_reg <= '0;
      else if (s3_valid_reg) acc_reg <= acc_reg + {{AW{det_reg[2*DW]}}, det_reg};
    end
  end

  assign acc_out = acc_reg;
`endif

  assign bus.rom_addr  = pc_reg;
  assign bus.det_out   = det_reg;
  assign bus.det_valid = s3_valid_reg & ~bus.hold;
  assign bus.busy      = (state_reg == RUN) || (state_reg == DRAIN);
  assign bus.done      = (state_reg == DONE) && !bus.hold;

endmodule

// File: tb/tb_det_stream_engine.sv
// tb_det_stream_engine: an unsigned and a signed engine run in lockstep from
// shared control inputs, each with its own ROM. Expected results come from an
// integer model of det = a*d - b*c queued at every start; a compare process
// checks every det_valid cycle. Run tasks check timing, addresses and busy/done.
module tb_det_stream_engine;
  localparam int DW = 4;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic [AW-1:0] base_addr;
  logic [AW:0] run_len;
  logic hold;
  int cyc = 0;
  int checks = 0;
  int errors = 0;

  logic [15:0] rom_u [16];
  logic [15:0] rom_s [16];
  logic [8:0] q_u[$], q_s[$], log_u[$], log_s[$];
  int acc_exp_u = 0;
  int acc_exp_s = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  det_stream_engine_if #(.DW(DW), .AW(AW)) ifu ();
  det_stream_engine_if #(.DW(DW), .AW(AW)) ifs ();

  assign ifu.start = start;     assign ifs.start = start;
  assign ifu.base_addr = base_addr; assign ifs.base_addr = base_addr;
  assign ifu.run_len = run_len; assign ifs.run_len = run_len;
  assign ifu.hold = hold;       assign ifs.hold = hold;
  assign ifu.rom_data = rom_u[ifu.rom_addr];
  assign ifs.rom_data = rom_s[ifs.rom_addr];

`ifdef DET_ACC_EN
  logic [2*DW+AW:0] acc_u, acc_s;
`endif

  det_stream_engine #(.DW(DW), .AW(AW), .SIGNED_MODE(0)) dut_u (
    .clk(clk), .reset(reset), .bus(ifu.master)
`ifdef DET_ACC_EN
    , .acc_out(acc_u)
`endif
  );

  det_stream_engine #(.DW(DW), .AW(AW), .SIGNED_MODE(1)) dut_s (
    .clk(clk), .reset(reset), .bus(ifs.master)
`ifdef DET_ACC_EN
    , .acc_out(acc_s)
`endif
  );

  function automatic logic [8:0] det_model(input logic [15:0] w, input bit sgn);
    int f[4];
    int r;
    for (int i = 0; i < 4; i++) begin
      f[i] = int'(w[i*4 +: 4]);
      if (sgn && f[i] > 7) f[i] = f[i] - 16;
    end
    // f[0]=a, f[1]=c, f[2]=d, f[3]=b
    r = f[0] * f[2] - f[3] * f[1];
    return 9'(r);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Compare process: every valid result must match the head of the model queue.
  always @(negedge clk) begin
    logic [8:0] e;
    if (ifu.det_valid === 1'b1) begin
      log_u.push_back(ifu.det_out);
      chk("valid_u_while_hold", 32'(hold), 32'd0);
      if (q_u.size() == 0) begin
        chk("det_u_unexpected", 32'(ifu.det_out), 32'h1ff0);
      end else begin
        e = q_u.pop_front();
        chk("det_u", 32'(ifu.det_out), 32'(e));
        acc_exp_u = acc_exp_u + int'($signed(e));
        $display("cycle %0d unsigned det_out=%h expected=%h", cyc, ifu.det_out, e);
      end
    end
    if (ifs.det_valid === 1'b1) begin
      log_s.push_back(ifs.det_out);
      if (q_s.size() == 0) begin
        chk("det_s_unexpected", 32'(ifs.det_out), 32'h1ff0);
      end else begin
        e = q_s.pop_front();
        chk("det_s", 32'(ifs.det_out), 32'(e));
        acc_exp_s = acc_exp_s + int'($signed(e));
        $display("cycle %0d signed   det_out=%h expected=%h", cyc, ifs.det_out, e);
      end
    end
  end

  // One run: start in relative cycle 0, optional hold window and stray start.
  task automatic run(input logic [3:0] base, input logic [4:0] len,
                     input int hlo, input int hhi, input int glitch,
                     input int exp_first, input int exp_done,
                     input bit aligned, input bit chk0);
    int t0, first, done_at;
    logic [3:0] prev_addr;
    if (!aligned) begin
      @(posedge clk); #1;
    end
    start = 1'b1; base_addr = base; run_len = len; hold = 1'b0;
    t0 = cyc;
    for (int k = 0; k < int'(len); k++) begin
      q_u.push_back(det_model(rom_u[(int'(base) + k) % 16], 1'b0));
      q_s.push_back(det_model(rom_s[(int'(base) + k) % 16], 1'b1));
    end
    acc_exp_u = 0; acc_exp_s = 0;
    log_u.delete(); log_s.delete();
    @(negedge clk);
    chk("done_at_start", 32'(ifu.done), 32'd0);
    if (chk0) begin
      chk("post_reset_addr", 32'(ifu.rom_addr), 32'd0);
      chk("post_reset_det", 32'(ifu.det_out), 32'd0);
      chk("post_reset_valid", 32'(ifu.det_valid), 32'd0);
      chk("post_reset_busy", 32'(ifu.busy), 32'd0);
    end
    first = -1; done_at = -1;
    prev_addr = ifu.rom_addr;
    for (int rel = 1; rel < 64 && done_at < 0; rel++) begin
      @(posedge clk); #1;
      start = (rel == glitch);
      base_addr = (rel == glitch) ? 4'h9 : base;
      hold = (rel >= hlo && rel <= hhi);
      @(negedge clk);
      if (hold && rel > hlo) chk("addr_frozen", 32'(ifu.rom_addr), 32'(prev_addr));
      else if (rel <= int'(len) && hlo > hhi)
        chk("addr_seq", 32'(ifu.rom_addr), 32'((int'(base) + rel - 1) % 16));
      prev_addr = ifu.rom_addr;
      if (ifu.det_valid && first < 0) first = rel;
      if (ifu.done) begin
        done_at = rel;
        chk("done_s", 32'(ifs.done), 32'd1);
        chk("busy_at_done", 32'(ifu.busy), 32'd0);
      end else begin
        chk("busy", 32'(ifu.busy), 32'(len != 0));
      end
    end
    chk("first_valid_cycle", 32'(first), 32'(exp_first));
    chk("done_cycle", 32'(done_at), 32'(exp_done));
    chk("queue_u_empty", 32'(q_u.size()), 32'd0);
    chk("queue_s_empty", 32'(q_s.size()), 32'd0);
`ifdef DET_ACC_EN
    chk("acc_u", 32'(acc_u), 32'(13'(acc_exp_u)));
    chk("acc_s", 32'(acc_s), 32'(13'(acc_exp_s)));
`endif
    $display("run base=%h len=%0d: first valid %0d, done %0d", base, len, first, done_at);
    q_u.delete(); q_s.delete();
  endtask

  // Reset in relative cycle 3 of a 4-word run, then restart at once.
  task automatic reset_mid_run();
    @(posedge clk); #1;
    start = 1'b1; base_addr = 4'h0; run_len = 5'd4; hold = 1'b0;
    for (int rel = 1; rel <= 3; rel++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (rel == 3) begin
        reset = 1'b1;
        // start with inputs of rel 1 = 3 trial: restart below
        if (rel == 2) start = 1'b1;
      end
      if (rel == 2) start = 1'b1;
      @(negedge clk);
      chk("no_done_before_reset", 32'(ifu.done), 32'd0);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    run(4'h2, 5'd1, 99, -1, 0, 4, 5, 1'b1, 1'b1);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      rom_u[i] = 16'(i * 16'h1357 + 16'h2468);
      rom_s[i] = 16'(i * 16'h2b1d + 16'h9c4e);
    end
    rom_u[0] = 16'h1234; rom_u[1] = 16'h4321;
    rom_u[3] = 16'h0FFF; rom_u[4] = 16'hF0F0;
    rom_s[0] = 16'h8888; rom_s[1] = 16'h8F18;
    reset = 1'b1; start = 1'b0; base_addr = '0; run_len = '0; hold = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_addr", 32'(ifu.rom_addr), 32'd0);
    chk("reset_det", 32'(ifu.det_out), 32'd0);
    chk("reset_valid", 32'(ifu.det_valid), 32'd0);
    chk("reset_busy", 32'(ifu.busy), 32'd0);
    chk("reset_done", 32'(ifu.done), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Basic run: pins 5, -5 (unsigned) and 0, +16 (signed)
    run(4'h0, 5'd2, 99, -1, 0, 4, 6, 1'b0, 1'b0);
    chk("pin_log_u_size", 32'(log_u.size()), 32'd2);
    chk("pin_log_s_size", 32'(log_s.size()), 32'd2);
    if (log_u.size() >= 2) begin
      chk("pin_u0", 32'(log_u[0]), 32'h005);
      chk("pin_u1", 32'(log_u[1]), 32'h1FB);
    end
    if (log_s.size() >= 2) begin
      chk("pin_s0", 32'(log_s[0]), 32'h000);
      chk("pin_s1", 32'(log_s[1]), 32'h010);
    end
`ifdef DET_ACC_EN
    chk("pin_acc_u", 32'(acc_u), 32'd0);
`endif

    // Unsigned extremes: 225 then -225
    run(4'h3, 5'd2, 99, -1, 0, 4, 6, 1'b0, 1'b0);
    if (log_u.size() >= 2) begin
      chk("pin_u_ext0", 32'(log_u[0]), 32'h0E1);
      chk("pin_u_ext1", 32'(log_u[1]), 32'h11F);
    end else begin
      chk("pin_u_ext_size", 32'(log_u.size()), 32'd2);
    end

    // Address wrap E, F, 0
    run(4'hE, 5'd3, 99, -1, 0, 4, 7, 1'b0, 1'b0);
    // Hold in cycles 2-3: everything slips by two cycles
    run(4'h0, 5'd2, 2, 3, 0, 6, 8, 1'b0, 1'b0);
    // Empty run
    run(4'h7, 5'd0, 99, -1, 0, -1, 1, 1'b0, 1'b0);
    // Stray start during RUN is ignored
    run(4'h1, 5'd3, 99, -1, 2, 4, 7, 1'b0, 1'b0);
    // Whole address space, once
    run(4'h5, 5'd16, 99, -1, 0, 4, 20, 1'b0, 1'b0);
    // Reset mid-run, then immediate restart
    reset_mid_run();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
